// File: rtl/rx_credit_buffer_pkg.sv
// Shared SpaceWire constants for the receive credit path: FCT quantum, credit ceiling,
// N-char codes and the FCT request state encoding.
package rx_credit_buffer_pkg;

  localparam int NCHAR_W     = 9;
  localparam int FCT_QUANTUM = 8;
  localparam int MAX_CREDIT  = 56;
  localparam int CRED_W      = $clog2(MAX_CREDIT + 1);

  localparam logic [NCHAR_W-1:0] EOP = 9'd256;
  localparam logic [NCHAR_W-1:0] EEP = 9'd257;

  typedef enum logic {
    FCT_IDLE = 1'b0,
    FCT_REQ  = 1'b1
  } fct_state_t;

endpackage

// File: rtl/rx_credit_buffer_if.sv
// Receive-side bundle between the SpaceWire decoder/TX flow control and the credit buffer.
// slave is the buffer's view, master is the surrounding link logic.
interface rx_credit_buffer_if #(
  parameter int AW = 6
);

  logic                                     rx_data_valid;
  logic [rx_credit_buffer_pkg::NCHAR_W-1:0] rx_data_flag;
  logic                                     fct_enable;
  logic                                     fct_sent;
  logic                                     fct_send_req;
  logic [rx_credit_buffer_pkg::NCHAR_W-1:0] rx_data_out;
  logic                                     rx_data_ready;
  logic                                     rx_data_take;
  logic                                     rx_credit_error;
  logic [AW:0]                              fifo_count;

  modport slave (
    input  rx_data_valid, rx_data_flag, fct_enable, fct_sent, rx_data_take,
    output fct_send_req, rx_data_out, rx_data_ready, rx_credit_error, fifo_count
  );

  modport master (
    output rx_data_valid, rx_data_flag, fct_enable, fct_sent, rx_data_take,
    input  fct_send_req, rx_data_out, rx_data_ready, rx_credit_error, fifo_count
  );

endinterface

// File: rtl/rx_credit_buffer_fifo.sv
// Show-ahead synchronous FIFO; pointers carry one extra wrap bit so full and empty
// are told apart by occupancy rather than by pointer equality.
module spw_sync_fifo #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 9
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_count
);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_push;
  logic         w_pop;

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (o_count == '0);
  assign o_full  = (o_count == (AW+1)'(DEPTH));
  assign w_push  = i_wr_en & ~o_full;
  assign w_pop   = i_rd_en & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is deliberately left out of reset; the empty gate below hides stale data.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr_data;
  end

  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

endmodule

// File: rtl/rx_credit_buffer.sv
// Receive N-char buffer with SpaceWire FCT credit accounting and FCT request handshake.
// FCT_IDLE: waiting for 8 free, uncommitted slots | FCT_REQ: FCT requested, awaiting fct_sent
module rx_credit_buffer
  import rx_credit_buffer_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic                 posedge_clk,
  input  logic                 rx_reset,
  rx_credit_buffer_if.slave    bus
);

  fct_state_t        r_state;
  fct_state_t        w_state_next;
  logic [CRED_W-1:0] r_cred_cnt;
  logic              r_credit_error;
  logic              w_fct_accept;
  logic              w_cred_dec;
  logic              w_room;
  logic              w_cred_ok;
  logic [AW+1:0]     w_committed;
  logic              w_empty;
  logic              w_full;

  spw_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (NCHAR_W)
  ) u_fifo (
    .i_clk     (posedge_clk),
    .i_rst     (rx_reset),
    .i_wr_en   (bus.rx_data_valid),
    .i_wr_data (bus.rx_data_flag),
    .i_rd_en   (bus.rx_data_take),
    .o_rd_data (bus.rx_data_out),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (bus.fifo_count)
  );

  assign bus.rx_data_ready = ~w_empty;

  // Slots already spoken for: stored chars plus chars the far end may still send.
  assign w_committed = {1'b0, bus.fifo_count} + (AW+2)'(r_cred_cnt);
  assign w_room      = (w_committed + (AW+2)'(FCT_QUANTUM)) <= (AW+2)'(DEPTH);
  assign w_cred_ok   = r_cred_cnt <= CRED_W'(MAX_CREDIT - FCT_QUANTUM);
  assign w_cred_dec  = bus.rx_data_valid & (r_cred_cnt != '0);

  always_ff @(posedge posedge_clk) begin
    if (rx_reset) r_state <= FCT_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next     = r_state;
    bus.fct_send_req = 1'b0;
    w_fct_accept     = 1'b0;
    case (r_state)
      FCT_IDLE: begin
        if (bus.fct_enable && w_room && w_cred_ok) w_state_next = FCT_REQ;
      end
      FCT_REQ: begin
        bus.fct_send_req = 1'b1;
        if (bus.fct_sent) begin
          w_state_next = FCT_IDLE;
          w_fct_accept = 1'b1;
        end
      end
      default: w_state_next = FCT_IDLE;
    endcase
    if (!bus.fct_enable) begin
      w_state_next = FCT_IDLE;
      w_fct_accept = 1'b0;
    end
  end

  always_ff @(posedge posedge_clk) begin
    if (rx_reset || !bus.fct_enable) begin
      r_cred_cnt <= '0;
    end else begin
      case ({w_fct_accept, w_cred_dec})
        2'b10:   r_cred_cnt <= r_cred_cnt + CRED_W'(FCT_QUANTUM);
        2'b11:   r_cred_cnt <= r_cred_cnt + CRED_W'(FCT_QUANTUM - 1);
        2'b01:   r_cred_cnt <= r_cred_cnt - 1'b1;
        default: r_cred_cnt <= r_cred_cnt;
      endcase
    end
  end

  always_ff @(posedge posedge_clk) begin
    if (rx_reset)                                         r_credit_error <= 1'b0;
    else if (bus.rx_data_valid && (r_cred_cnt == '0))     r_credit_error <= 1'b1;
  end

  assign bus.rx_credit_error = r_credit_error;

endmodule

// File: tb/tb_rx_credit_buffer.sv
// Directed bench for rx_credit_buffer: FCT handshake, credit accounting, FIFO order and limits.
module tb_rx_credit_buffer;
  import rx_credit_buffer_pkg::*;

  logic posedge_clk = 1'b0;
  logic rx_reset;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_req;

  rx_credit_buffer_if #(.AW(6)) bus();

  rx_credit_buffer #(.DEPTH(64), .AW(6)) dut (
    .posedge_clk (posedge_clk),
    .rx_reset    (rx_reset),
    .bus         (bus.slave)
  );

  always #5 posedge_clk = ~posedge_clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge posedge_clk);
    #1;
  endtask

  task automatic write_char(input logic [8:0] d);
    bus.rx_data_valid = 1'b1;
    bus.rx_data_flag  = d;
    tick();
    bus.rx_data_valid = 1'b0;
  endtask

  task automatic take();
    bus.rx_data_take = 1'b1;
    tick();
    bus.rx_data_take = 1'b0;
  endtask

  task automatic serve_fct(input int ncyc, output int nreq);
    nreq = 0;
    for (int i = 0; i < ncyc; i++) begin
      if (bus.fct_send_req) begin
        nreq++;
        bus.fct_sent = 1'b1;
      end
      tick();
      bus.fct_sent = 1'b0;
    end
  endtask

  always @(negedge posedge_clk) begin
    if (rx_reset === 1'b0)
      check_val("invariant", ((bus.fifo_count + dut.r_cred_cnt) <= 64) ? 1 : 0, 1);
  end

  initial begin
    rx_reset          = 1'b1;
    bus.rx_data_valid = 1'b0;
    bus.rx_data_flag  = '0;
    bus.fct_enable    = 1'b0;
    bus.fct_sent      = 1'b0;
    bus.rx_data_take  = 1'b0;
    repeat (2) tick();
    check_val("rst_req",   bus.fct_send_req,    0);
    check_val("rst_ready", bus.rx_data_ready,   0);
    check_val("rst_count", bus.fifo_count,      0);
    check_val("rst_out",   bus.rx_data_out,     0);
    check_val("rst_err",   bus.rx_credit_error, 0);
    check_val("rst_cred",  dut.r_cred_cnt,      0);

    // Start-up: seven FCTs take credit from 0 to 56, then requests stop.
    rx_reset       = 1'b0;
    bus.fct_enable = 1'b1;
    serve_fct(40, n_req);
    check_val("startup_fcts", n_req, 7);
    check_val("startup_cred", dut.r_cred_cnt, 56);
    serve_fct(10, n_req);
    check_val("no_req_at_56", n_req, 0);

    // Eight chars consume credit down to 48, which earns exactly one more FCT.
    for (int i = 1; i <= 8; i++) write_char(9'(i));
    check_val("cred_after_8", dut.r_cred_cnt, 48);
    check_val("count_after_8", bus.fifo_count, 8);
    check_val("head_after_8", bus.rx_data_out, 9'h001);
    serve_fct(10, n_req);
    check_val("refill_fcts", n_req, 1);
    check_val("refill_cred", dut.r_cred_cnt, 56);

    for (int i = 1; i <= 8; i++) begin
      check_val("drain8", bus.rx_data_out, 9'(i));
      take();
    end
    check_val("drain8_empty", bus.rx_data_ready, 0);

    // Data then EOP: show-ahead order, one-cycle visibility, flag bit preserved.
    write_char(9'h0A5);
    check_val("a5_ready", bus.rx_data_ready, 1);
    check_val("a5_out", bus.rx_data_out, 9'h0A5);
    write_char(EOP);
    check_val("eop_head_kept", bus.rx_data_out, 9'h0A5);
    check_val("eop_count", bus.fifo_count, 2);
    take();
    check_val("eop_out", bus.rx_data_out, 9'd256);
    take();
    check_val("eop_ready_low", bus.rx_data_ready, 0);
    check_val("eop_out_zero", bus.rx_data_out, 0);

    // Simultaneous read and write leaves occupancy unchanged.
    write_char(9'h011);
    bus.rx_data_valid = 1'b1;
    bus.rx_data_flag  = 9'h022;
    bus.rx_data_take  = 1'b1;
    tick();
    bus.rx_data_valid = 1'b0;
    bus.rx_data_take  = 1'b0;
    check_val("rw_count", bus.fifo_count, 1);
    check_val("rw_head", bus.rx_data_out, 9'h022);
    take();
    check_val("rw_cred", dut.r_cred_cnt, 52);

    // Link drop clears credit; a char at zero credit flags error but is stored.
    bus.fct_enable = 1'b0;
    tick();
    check_val("disable_cred", dut.r_cred_cnt, 0);
    write_char(9'h055);
    check_val("cerr_flag", bus.rx_credit_error, 1);
    check_val("cerr_count", bus.fifo_count, 1);
    check_val("cerr_head", bus.rx_data_out, 9'h055);
    check_val("cerr_cred", dut.r_cred_cnt, 0);

    // Fill to 64, then overflow write must be dropped.
    for (int i = 1; i <= 63; i++) write_char(9'(i));
    check_val("full_count", bus.fifo_count, 64);
    write_char(9'h1FF);
    check_val("ovf_count", bus.fifo_count, 64);
    check_val("ovf_head", bus.rx_data_out, 9'h055);
    take();
    for (int i = 1; i <= 63; i++) begin
      check_val("full_drain", bus.rx_data_out, 9'(i));
      take();
    end
    check_val("full_drain_empty", bus.rx_data_ready, 0);
    check_val("err_sticky", bus.rx_credit_error, 1);

    // Drop fct_enable while in REQ.
    write_char(9'h0C3);
    bus.fct_enable = 1'b1;
    tick();
    check_val("req_raised", bus.fct_send_req, 1);
    bus.fct_enable = 1'b0;
    tick();
    check_val("drop_req", bus.fct_send_req, 0);
    check_val("drop_cred", dut.r_cred_cnt, 0);
    check_val("drop_count", bus.fifo_count, 1);
    check_val("drop_head", bus.rx_data_out, 9'h0C3);
    check_val("drop_err_kept", bus.rx_credit_error, 1);

    // Reset mid-handshake; a late fct_sent must not add credit.
    bus.fct_enable = 1'b1;
    tick();
    check_val("req_before_rst", bus.fct_send_req, 1);
    rx_reset = 1'b1;
    tick();
    check_val("rst_mid_req", bus.fct_send_req, 0);
    check_val("rst_mid_count", bus.fifo_count, 0);
    check_val("rst_mid_err", bus.rx_credit_error, 0);
    rx_reset       = 1'b0;
    bus.fct_enable = 1'b0;
    bus.fct_sent   = 1'b1;
    tick();
    bus.fct_sent   = 1'b0;
    check_val("late_sent_ignored", dut.r_cred_cnt, 0);

    // fct_sent coincident with a char: 8 - 1 + 8 = 15.
    bus.fct_enable = 1'b1;
    tick();
    check_val("net_req1", bus.fct_send_req, 1);
    bus.fct_sent = 1'b1;
    tick();
    bus.fct_sent = 1'b0;
    check_val("net_cred8", dut.r_cred_cnt, 8);
    tick();
    check_val("net_req2", bus.fct_send_req, 1);
    bus.fct_sent      = 1'b1;
    bus.rx_data_valid = 1'b1;
    bus.rx_data_flag  = 9'h033;
    tick();
    bus.fct_sent      = 1'b0;
    bus.rx_data_valid = 1'b0;
    check_val("net_plus7", dut.r_cred_cnt, 15);
    check_val("net_count", bus.fifo_count, 1);
    check_val("net_no_err", bus.rx_credit_error, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
